// File: rtl/iob_aclint.sv
// ACLINT-style machine timer + software interrupt block on the native valid/ready bus.
// Optional IOB_ACLINT_RTC_EN: mtime is clocked by synchronised rt_clk rising edges instead of clk.
module iob_aclint #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int N_HARTS    = 1,
  parameter int MTIME_W    = 64,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef IOB_ACLINT_RTC_EN
  input  logic                  rt_clk,
`endif
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  output logic [N_HARTS-1:0]    mtip,
  output logic [N_HARTS-1:0]    msip
);

  localparam int WA_W = ADDR_W - 2;
  localparam int HI_W = MTIME_W - 32;
  localparam int CMP_BASE = 32'h1000;
  localparam logic [WA_W-1:0] PRESCALE_WA = WA_W'(32'h2FFC);
  localparam logic [WA_W-1:0] CTRL_WA     = WA_W'(32'h2FFD);
  localparam logic [WA_W-1:0] MTIME_LO_WA = WA_W'(32'h2FFE);
  localparam logic [WA_W-1:0] MTIME_HI_WA = WA_W'(32'h2FFF);

  logic [WA_W-1:0]       word_addr;
  logic                  unused_addr;
  logic                  wr_en, rd_en;
  logic                  prescale_sel, ctrl_sel, mtime_lo_sel, mtime_hi_sel;
  logic [MTIME_W-1:0]    mtime_reg;
  logic [HI_W-1:0]       snapshot_reg;
  logic [PRESCALE_W-1:0] prescale_reg, count_reg;
  logic                  en_reg;
  logic                  tick_src, tick;
  logic [DATA_W-1:0]     rdata_reg;
  logic                  ready_reg;
  logic [31:0]           rd_mux;
  logic [31:0]           hart_rdata [N_HARTS];

  assign word_addr    = address[ADDR_W-1:2];
  assign unused_addr  = ^address[1:0];
  assign wr_en        = valid & (|wstrb);
  assign rd_en        = valid & ~(|wstrb);
  assign prescale_sel = (word_addr == PRESCALE_WA);
  assign ctrl_sel     = (word_addr == CTRL_WA);
  assign mtime_lo_sel = (word_addr == MTIME_LO_WA);
  assign mtime_hi_sel = (word_addr == MTIME_HI_WA);

`ifdef IOB_ACLINT_RTC_EN
  // Two synchroniser stages, third stage only remembers the previous level for edge detection.
  logic [2:0] rt_sync_reg;
  always_ff @(posedge clk) begin
    if (rst) rt_sync_reg <= '0;
    else     rt_sync_reg <= {rt_sync_reg[1:0], rt_clk};
  end
  assign tick_src = rt_sync_reg[1] & ~rt_sync_reg[2];
`else
  assign tick_src = 1'b1;
`endif

  assign tick = en_reg & tick_src & (count_reg == prescale_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_reg <= '0;
      en_reg       <= 1'b1;
      count_reg    <= '0;
    end else begin
      if (wr_en && prescale_sel) prescale_reg <= wdata[PRESCALE_W-1:0];
      if (wr_en && ctrl_sel)     en_reg       <= wdata[0];
      if ((wr_en && prescale_sel) || (wr_en && ctrl_sel && !wdata[0]))
        count_reg <= '0;
      else if (en_reg && tick_src)
        count_reg <= tick ? '0 : count_reg + PRESCALE_W'(1);
    end
  end

  // A bus write to either half of mtime takes priority and swallows a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_reg    <= '0;
      snapshot_reg <= '0;
    end else begin
      if (wr_en && mtime_lo_sel)      mtime_reg[31:0]         <= wdata[31:0];
      else if (wr_en && mtime_hi_sel) mtime_reg[MTIME_W-1:32] <= wdata[HI_W-1:0];
      else if (tick)                  mtime_reg               <= mtime_reg + MTIME_W'(1);
      if (rd_en && mtime_lo_sel)      snapshot_reg            <= mtime_reg[MTIME_W-1:32];
    end
  end

  generate
    for (genvar gi = 0; gi < N_HARTS; gi++) begin : g_hart
      logic               msip_sel, cmp_lo_sel, cmp_hi_sel;
      logic [MTIME_W-1:0] mtimecmp_reg;
      logic               msip_reg, mtip_reg;

      assign msip_sel   = (word_addr == WA_W'(gi));
      assign cmp_lo_sel = (word_addr == WA_W'(CMP_BASE + 2*gi));
      assign cmp_hi_sel = (word_addr == WA_W'(CMP_BASE + 2*gi + 1));

      always_ff @(posedge clk) begin
        if (rst) begin
          mtimecmp_reg <= '1;
          msip_reg     <= 1'b0;
          mtip_reg     <= 1'b0;
        end else begin
          if (wr_en && cmp_lo_sel) mtimecmp_reg[31:0]         <= wdata[31:0];
          if (wr_en && cmp_hi_sel) mtimecmp_reg[MTIME_W-1:32] <= wdata[HI_W-1:0];
          if (wr_en && msip_sel)   msip_reg                   <= wdata[0];
          mtip_reg <= (mtime_reg >= mtimecmp_reg);
        end
      end

      assign msip[gi] = msip_reg;
      assign mtip[gi] = mtip_reg;
      assign hart_rdata[gi] = msip_sel   ? {31'b0, msip_reg} :
                              cmp_lo_sel ? mtimecmp_reg[31:0] :
                              cmp_hi_sel ? 32'(mtimecmp_reg[MTIME_W-1:32]) : 32'b0;
    end
  endgenerate

  // Hart decodes are mutually exclusive with each other and with the global registers.
  always_comb begin
    rd_mux = '0;
    for (int h = 0; h < N_HARTS; h++) rd_mux = rd_mux | hart_rdata[h];
    if (prescale_sel)      rd_mux = 32'(prescale_reg);
    else if (ctrl_sel)     rd_mux = {31'b0, en_reg};
    else if (mtime_lo_sel) rd_mux = mtime_reg[31:0];
    else if (mtime_hi_sel) rd_mux = 32'(snapshot_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
      ready_reg <= 1'b0;
    end else begin
      rdata_reg <= rd_en ? rd_mux : '0;
      ready_reg <= valid;
    end
  end

  assign rdata = rdata_reg;
  assign ready = ready_reg;

endmodule

// File: tb/tb_iob_aclint.sv
// Directed bench for iob_aclint (default build, two harts): reset, prescaler, compare,
// wrap/atomic read, write/tick collision, MSIP and unmapped accesses.
module tb_iob_aclint;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic [1:0]  mtip;
  logic [1:0]  msip;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  iob_aclint #(
    .ADDR_W(16), .DATA_W(32), .N_HARTS(2), .MTIME_W(64), .PRESCALE_W(16)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .mtip(mtip), .msip(msip)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Each bus task starts just after a negedge and returns at the next negedge.
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    valid = 1'b1; address = a; wdata = d; wstrb = 4'hF;
    @(negedge clk);
    valid = 1'b0; wstrb = 4'h0;
    $display("wr addr=0x%04h data=0x%08h", a, d);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    valid = 1'b1; address = a; wstrb = 4'h0;
    @(negedge clk);
    valid = 1'b0;
    $display("rd addr=0x%04h data=0x%08h", a, rdata);
    check(tag, rdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; address = '0; wdata = '0; wstrb = '0;
    idle(2);
    rst = 1'b0;

    // Reset state
    check("rst_mtip", 32'(mtip), 32'h0);
    check("rst_msip", 32'(msip), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rd_chk("rst_cmp0_lo", 16'h4000, 32'hFFFF_FFFF);
    check("rd_ready", 32'(ready), 32'h1);
    rd_chk("rst_cmp0_hi", 16'h4004, 32'hFFFF_FFFF);
    rd_chk("rst_cmp1_hi", 16'h400C, 32'hFFFF_FFFF);
    rd_chk("rst_ctrl", 16'hBFF4, 32'h1);
    rd_chk("rst_prescale", 16'hBFF0, 32'h0);
    idle(1);
    check("idle_ready", 32'(ready), 32'h0);
    check("idle_rdata", rdata, 32'h0);

    // Prescaler: PRESCALE=3 -> one increment every 4 clocks
    wr(16'hBFF4, 32'h0);
    check("wr_ready", 32'(ready), 32'h1);
    check("wr_rdata", rdata, 32'h0);
    wr(16'hBFF8, 32'h0);
    wr(16'hBFFC, 32'h0);
    wr(16'hBFF0, 32'h3);
    wr(16'hBFF4, 32'h1);
    for (int j = 1; j <= 9; j++) rd_chk($sformatf("pre_run%0d", j), 16'hBFF8, 32'((j - 1) / 4));
    wr(16'hBFF4, 32'h0);
    idle(5);
    rd_chk("pre_frozen", 16'hBFF8, 32'h2);
    wr(16'hBFF4, 32'h1);
    for (int j = 1; j <= 5; j++) rd_chk($sformatf("pre_resume%0d", j), 16'hBFF8, 32'(2 + (j - 1) / 4));

    // Compare: mtimecmp[1]=10, PRESCALE=0
    wr(16'hBFF4, 32'h0);
    wr(16'hBFF0, 32'h0);
    wr(16'h400C, 32'h0);
    wr(16'h4008, 32'd10);
    wr(16'hBFFC, 32'h0);
    wr(16'hBFF8, 32'h0);
    idle(1);
    check("cmp_idle_mtip", 32'(mtip), 32'h0);
    wr(16'hBFF4, 32'h1);
    idle(10);
    check("cmp_before", 32'(mtip), 32'h0);
    idle(1);
    check("cmp_rise", 32'(mtip), 32'h2);
    wr(16'h400C, 32'h1);
    check("cmp_hold", 32'(mtip), 32'h2);
    idle(1);
    check("cmp_clear", 32'(mtip), 32'h0);

    // Wrap from all ones
    wr(16'hBFF4, 32'h0);
    wr(16'hBFF8, 32'hFFFF_FFFF);
    wr(16'hBFFC, 32'hFFFF_FFFF);
    wr(16'hBFF4, 32'h1);
    check("wrap_mtip_eq", 32'(mtip), 32'h3);
    rd_chk("wrap_lo0", 16'hBFF8, 32'hFFFF_FFFF);
    rd_chk("wrap_hi0", 16'hBFFC, 32'hFFFF_FFFF);
    rd_chk("wrap_lo1", 16'hBFF8, 32'h1);
    rd_chk("wrap_hi1", 16'hBFFC, 32'h0);

    // Atomic read across the 32-bit carry
    wr(16'hBFF4, 32'h0);
    wr(16'hBFF8, 32'hFFFF_FFFF);
    wr(16'hBFFC, 32'h0);
    wr(16'hBFF4, 32'h1);
    rd_chk("atom_lo0", 16'hBFF8, 32'hFFFF_FFFF);
    rd_chk("atom_hi0", 16'hBFFC, 32'h0);
    rd_chk("atom_lo1", 16'hBFF8, 32'h1);
    rd_chk("atom_hi1", 16'hBFFC, 32'h1);

    // Write/tick collision while ticking every clock
    wr(16'hBFFC, 32'h0);
    wr(16'hBFF8, 32'h100);
    rd_chk("coll_lo", 16'hBFF8, 32'h100);
    rd_chk("coll_hi", 16'hBFFC, 32'h0);
    rd_chk("coll_run", 16'hBFF8, 32'h102);

    // MSIP
    wr(16'h0000, 32'h1);
    check("msip0_set", 32'(msip), 32'h1);
    rd_chk("msip0_rd", 16'h0000, 32'h1);
    wr(16'h0008, 32'h1);
    check("msip_unmapped_wr", 32'(msip), 32'h1);
    rd_chk("msip_unmapped_rd", 16'h0008, 32'h0);
    wr(16'h0004, 32'hFFFF_FFFF);
    check("msip1_set", 32'(msip), 32'h3);
    rd_chk("msip1_rd", 16'h0004, 32'h1);
    wr(16'h0000, 32'h0);
    check("msip0_clr", 32'(msip), 32'h2);

    // Unmapped space and PRESCALE width
    wr(16'h4010, 32'h5);
    rd_chk("cmp_unmapped", 16'h4010, 32'h0);
    rd_chk("unmapped_1234", 16'h1234, 32'h0);
    check("unmapped_ready", 32'(ready), 32'h1);
    rd_chk("unmapped_bfe0", 16'hBFE0, 32'h0);
    wr(16'hBFF0, 32'hFFFF_FFFF);
    rd_chk("prescale_width", 16'hBFF0, 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
